// File: rtl/contador_descendente_nbits.sv
// Loadable N-bit down-counter/timer with terminal-count pulse and IDLE/RUN/DONE status.
// Define AUTO_RELOAD_EN to reload from the last loaded value at terminal count instead of stopping.
module contador_descendente_nbits #(
  parameter int N = 8
) (
  input  logic         clk_reloj,
  input  logic         rst_reset_n,
  input  logic         en_enable,
  input  logic         clr_clear,
  input  logic         ld_load,
  input  logic         start,
  input  logic [N-1:0] d_valor,
  output logic [N-1:0] q,
  output logic         tc,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] q_q, q_d;
  logic         tc_q, tc_d;
`ifdef AUTO_RELOAD_EN
  logic [N-1:0] reload_q, reload_d;
`endif

  logic q_is_zero;
  logic q_is_one;
  logic d_is_zero;
  logic tick;
  logic terminal;

  // A tick only counts in RUN when neither clear nor load claims the edge.
  assign q_is_zero = (q_q == '0);
  assign q_is_one  = (q_q == N'(1));
  assign d_is_zero = (d_valor == '0);
  assign tick      = (state_q == RUN) && en_enable && !clr_clear && !ld_load;
  assign terminal  = tick && q_is_one;

  always_ff @(posedge clk_reloj or negedge rst_reset_n) begin
    if (!rst_reset_n) begin
      state_q  <= IDLE;
      q_q      <= '0;
      tc_q     <= 1'b0;
`ifdef AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      tc_q     <= tc_d;
`ifdef AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    if (clr_clear) begin
      state_d = IDLE;
    end else if (ld_load) begin
      if (d_is_zero) begin
        state_d = IDLE;
      end else if (start || (state_q == RUN)) begin
        state_d = RUN;
      end else begin
        state_d = IDLE;
      end
    end else if (start && (state_q != RUN) && !q_is_zero) begin
      state_d = RUN;
`ifdef AUTO_RELOAD_EN
    end else if (terminal && (reload_q == '0)) begin
`else
    end else if (terminal) begin
`endif
      state_d = DONE;
    end
  end

  always_comb begin
    q_d  = q_q;
    tc_d = 1'b0;
`ifdef AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    if (clr_clear) begin
      q_d = '0;
    end else if (ld_load) begin
      q_d = d_valor;
`ifdef AUTO_RELOAD_EN
      reload_d = d_valor;
`endif
    end else if (tick && !q_is_zero) begin
      if (q_is_one) begin
        tc_d = 1'b1;
`ifdef AUTO_RELOAD_EN
        q_d  = reload_q;
`else
        q_d  = '0;
`endif
      end else begin
        q_d = q_q - N'(1);
      end
    end
  end

  always_comb begin
    q    = q_q;
    tc   = tc_q;
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

endmodule

// File: tb/tb_contador_descendente_nbits.sv
// Self-checking bench for contador_descendente_nbits (N = 8): vector table plus directed sequences.
module tb_contador_descendente_nbits;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, clr = 1'b0, ld = 1'b0, st = 1'b0;
  logic [7:0] dv = 8'd0;
  logic [7:0] q;
  logic       tc, busy, done;

  int n_checks = 0;
  int n_pass   = 0;

  contador_descendente_nbits #(.N(8)) dut (
    .clk_reloj   (clk),
    .rst_reset_n (rst_n),
    .en_enable   (en),
    .clr_clear   (clr),
    .ld_load     (ld),
    .start       (st),
    .d_valor     (dv),
    .q           (q),
    .tc          (tc),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ld, st, en, clr;
    logic [7:0] d;
    logic [7:0] eq;
    logic       etc, ebusy, edone;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step(input logic l, input logic s, input logic e, input logic c, input logic [7:0] d);
    @(negedge clk);
    ld = l; st = s; en = e; clr = c; dv = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm, input logic [7:0] eq, input logic etc,
                         input logic eb, input logic ed);
    chk({nm, ".q"}, 32'(q), 32'(eq));
    chk({nm, ".tc"}, 32'(tc), 32'(etc));
    chk({nm, ".busy"}, 32'(busy), 32'(eb));
    chk({nm, ".done"}, 32'(done), 32'(ed));
  endtask

  initial begin
`ifndef AUTO_RELOAD_EN
    vec_t vecs[$];
    int   lat;
`else
    int   pulses;
`endif
    #1;
    chk_all("reset", 8'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset while running
    step(1, 1, 0, 0, 8'h37);
    chk_all("rst_mid.load", 8'h37, 1'b0, 1'b1, 1'b0);
    step(0, 0, 0, 0, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("rst_mid.async", 8'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0, 8'h00);
      chk_all("rst_mid.after", 8'd0, 1'b0, 1'b0, 1'b0);
    end

`ifndef AUTO_RELOAD_EN
    // Latency: load 7 with continuous tick, tc exactly 7 edges after RUN entry
    step(1, 1, 1, 0, 8'd7);
    chk_all("lat.entry", 8'd7, 1'b0, 1'b1, 1'b0);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      step(0, 0, 1, 0, 8'd0);
      if (tc === 1'b1) begin
        lat = c;
        break;
      end
    end
    chk("lat.cycles", 32'(lat), 32'd7);
    chk_all("lat.term", 8'd0, 1'b1, 1'b0, 1'b1);
    step(0, 0, 1, 0, 8'd0);
    chk("lat.tc_one_cycle", 32'(tc), 32'd0);

    //                   ld st en clr d      q      tc busy done
    vecs.push_back(vec_t'{1, 1, 1, 0, 8'd5,  8'd5,  0, 1, 0});
    vecs.push_back(vec_t'{0, 0, 1, 0, 8'd0,  8'd4,  0, 1, 0});
    vecs.push_back(vec_t'{0, 0, 1, 0, 8'd0,  8'd3,  0, 1, 0});
    vecs.push_back(vec_t'{0, 0, 1, 0, 8'd0,  8'd2,  0, 1, 0});
    vecs.push_back(vec_t'{0, 0, 1, 0, 8'd0,  8'd1,  0, 1, 0});
    vecs.push_back(vec_t'{0, 0, 1, 0, 8'd0,  8'd0,  1, 0, 1});
    vecs.push_back(vec_t'{0, 0, 1, 0, 8'd0,  8'd0,  0, 0, 1});
    vecs.push_back(vec_t'{0, 0, 1, 0, 8'd0,  8'd0,  0, 0, 1});
    // gated ticks
    vecs.push_back(vec_t'{1, 1, 0, 0, 8'd3,  8'd3,  0, 1, 0});
    vecs.push_back(vec_t'{0, 0, 1, 0, 8'd0,  8'd2,  0, 1, 0});
    vecs.push_back(vec_t'{0, 0, 0, 0, 8'd0,  8'd2,  0, 1, 0});
    vecs.push_back(vec_t'{0, 0, 1, 0, 8'd0,  8'd1,  0, 1, 0});
    vecs.push_back(vec_t'{0, 0, 0, 0, 8'd0,  8'd1,  0, 1, 0});
    vecs.push_back(vec_t'{0, 0, 1, 0, 8'd0,  8'd0,  1, 0, 1});
    vecs.push_back(vec_t'{0, 0, 0, 0, 8'd0,  8'd0,  0, 0, 1});
    // clear, start with q == 0, load 0 while running
    vecs.push_back(vec_t'{0, 0, 0, 1, 8'd0,  8'd0,  0, 0, 0});
    vecs.push_back(vec_t'{0, 1, 1, 0, 8'd0,  8'd0,  0, 0, 0});
    vecs.push_back(vec_t'{1, 1, 0, 0, 8'd4,  8'd4,  0, 1, 0});
    vecs.push_back(vec_t'{1, 0, 1, 0, 8'd0,  8'd0,  0, 0, 0});
    vecs.push_back(vec_t'{0, 0, 1, 0, 8'd0,  8'd0,  0, 0, 0});
    // reload while running, clear beats load
    vecs.push_back(vec_t'{1, 1, 1, 0, 8'd10, 8'd10, 0, 1, 0});
    vecs.push_back(vec_t'{0, 0, 1, 0, 8'd0,  8'd9,  0, 1, 0});
    vecs.push_back(vec_t'{1, 0, 1, 0, 8'h20, 8'h20, 0, 1, 0});
    vecs.push_back(vec_t'{0, 0, 1, 0, 8'd0,  8'h1f, 0, 1, 0});
    vecs.push_back(vec_t'{1, 1, 1, 1, 8'h44, 8'd0,  0, 0, 0});
    vecs.push_back(vec_t'{0, 0, 1, 0, 8'd0,  8'd0,  0, 0, 0});
    // load without start stays IDLE, start later, start in RUN ignored
    vecs.push_back(vec_t'{1, 0, 1, 0, 8'd2,  8'd2,  0, 0, 0});
    vecs.push_back(vec_t'{0, 1, 1, 0, 8'd0,  8'd2,  0, 1, 0});
    vecs.push_back(vec_t'{0, 0, 1, 0, 8'd0,  8'd1,  0, 1, 0});
    vecs.push_back(vec_t'{0, 1, 1, 0, 8'd0,  8'd0,  1, 0, 1});
    vecs.push_back(vec_t'{0, 1, 1, 0, 8'd0,  8'd0,  0, 0, 1});

    foreach (vecs[i]) begin
      step(vecs[i].ld, vecs[i].st, vecs[i].en, vecs[i].clr, vecs[i].d);
      chk_all($sformatf("vec%0d", i), vecs[i].eq, vecs[i].etc, vecs[i].ebusy, vecs[i].edone);
    end
`else
    // Auto-reload period 3 over 12 ticks
    step(1, 1, 1, 0, 8'd3);
    chk_all("ar.entry", 8'd3, 1'b0, 1'b1, 1'b0);
    pulses = 0;
    for (int k = 1; k <= 12; k++) begin
      step(0, 0, 1, 0, 8'd0);
      if (tc === 1'b1) pulses++;
      chk_all($sformatf("ar%0d", k), 8'(3 - (k % 3)), (k % 3) == 0, 1'b1, 1'b0);
    end
    chk("ar.pulses", 32'(pulses), 32'd4);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
